pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline stage register that replaces the fixed stall/flush stage registers between CPU pipeline stages. It carries a DATA_W-bit payload with valid/ready handshaking and a two-entry skid buffer, so back-pressure timing is fully registered. It supports a flush that discards in-flight entries and an optional zeroing of the payload. Instances sit between E/M, M/W and similar stage boundaries, with the stage bundle packed into one vector.

## Interface
- DATA_W, 64: payload width in bits; must be ≥1.
- FLUSH_ZERO, 1: 1 = flush and reset clear stored payload to 0; 0 = flush and reset clear only valid bits.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries and the input beat this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; a transfer occurs when in_valid & in_ready & ~flush.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- out_data  out  DATA_W  payload of the oldest held entry.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d). out_valid = main_v and out_data = main_d. in_ready = ~skid_v. occupancy = main_v + skid_v.
- States: EMPTY (0 entries), ONE (main only), TWO (main and skid). The skid register is never valid while main is invalid.
- Transitions. Let push = in_valid & in_ready and pop = out_valid & out_ready.
  - EMPTY: push loads main and goes to ONE.
  - ONE, push and pop: main gets in_data; stay in ONE.
  - ONE, push only: skid gets in_data; go to TWO.
  - ONE, pop only: go to EMPTY.
  - TWO, pop: main gets skid; skid_v goes to 0; go to ONE. Push cannot occur because in_ready is 0.
  - TWO, no pop: hold.
- Ordering is strict FIFO. There is no payload modification and no reordering.
- Flush has priority over push and pop. On the next edge main_v and skid_v go to 0 and the state goes to EMPTY.
  - A pop in the flush cycle still counts as a completed transfer downstream. The stage only drops its own copies.
  - The input beat in the flush cycle is dropped even if in_ready=1.
  - Payload registers are set to 0 only if FLUSH_ZERO=1; otherwise they hold.
- Reset has priority over flush: state EMPTY; payload registers 0 if FLUSH_ZERO=1.
- Width rules: payload is passed bit-exact with no truncation. Callers pack and slice, e.g. alu_out[31:0] is sliced before in_data.

## Timing
- Reset values (after the rst edge): out_valid=0, in_ready=1, occupancy=0. out_data=0 if FLUSH_ZERO=1, otherwise undefined.
- Latency: beat accepted at edge N is visible on out_data/out_valid after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- All outputs come directly from flops with no combinational path between the two sides:
  - in_ready depends only on skid_v.
  - out_valid and out_data depend only on the main register.
- Back-pressure: with out_ready low from cycle N, at most 2 beats are held.
  - in_ready falls the cycle after the second beat is accepted.
  - in_ready rises the cycle after the first pop from TWO.
- Simultaneous flush+push+pop: result is EMPTY, pop counted, push dropped.
- rst during TWO: EMPTY next cycle; both entries lost.
- Handshake rule: upstream must hold in_valid/in_data stable until accepted; this is not checked by the stage.

## Structure
- A shared package pipe_pkg holds:
  - The state enum stage_st_e {ST_EMPTY, ST_ONE, ST_TWO}.
  - Occupancy width constant OCC_W=2.
  - Per-boundary payload struct typedefs and their packed widths (e.g. em_bundle_t).
- Single module with no sub-modules. Stage-specific wrappers, e.g. an E/M wrapper, only pack and unpack structs.

## Test plan
- Reset: assert rst for 2 cycles with FLUSH_ZERO=1 → out_valid=0, in_ready=1, occupancy=0, out_data=0.
- Streaming: out_ready=1, push 0x01..0x08 on consecutive cycles → same values appear 1 cycle later, in order, with no bubbles.
- Back-pressure: out_ready=0, push 0xA, 0xB, 0xC →
  - 0xA and 0xB are held and occupancy=2.
  - in_ready=0 while 0xC is offered, so 0xC is not accepted.
  - Raise out_ready → 0xA, 0xB, 0xC are delivered in order.
- Flush in TWO with simultaneous push 0xD and pop → 0xA is popped, 0xD is dropped, next cycle out_valid=0 and occupancy=0.
- FLUSH_ZERO=0: flush while holding 0x55 → out_valid=0 and out_data still 0x55.
- Random valid/ready/flush over 10k cycles against a scoreboard queue → no loss except flushed beats, no duplication, occupancy ≤2.

Source files
------------

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers:
//   - stage_st_e : occupancy state of a skid stage (EMPTY / ONE / TWO)
//   - OCC_W      : width of the occupancy count (0..2)
//   - per-boundary payload bundles and their packed widths, so a boundary
//     wrapper can pack its struct straight into the stage's DATA_W vector
//   - occ_count(): occupancy from the two valid bits
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_st_e;

    localparam int OCC_W = 2;

    // Execute -> Memory boundary bundle.
    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } em_bundle_t;

    localparam int EM_BUNDLE_W = $bits(em_bundle_t);

    // Memory -> Writeback boundary bundle.
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mw_bundle_t;

    localparam int MW_BUNDLE_W = $bits(mw_bundle_t);

    // Number of held entries; skid is never valid without main.
    function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
        occ_count = {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_stage.sv
// ----------------------------------------------------------------------------
// pipe_skid_stage
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer. Every output comes straight from flops, so neither the ready path
// nor the valid/data path crosses the stage combinationally.
//
// Parameters:
//   DATA_W     payload width in bits (>= 1)
//   FLUSH_ZERO 1: flush and reset also clear stored payload to 0
//              0: flush and reset clear only the valid bits
//
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset (priority over flush)
//   flush      drop all held entries and this cycle's input beat
//   in_valid   upstream beat present
//   in_ready   stage can accept (== ~skid valid)
//   in_data    upstream payload
//   out_valid  downstream beat present (== main valid)
//   out_ready  downstream accepts
//   out_data   oldest held payload (== main payload)
//   occupancy  held entries, 0..2
// ----------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    stage_st_e         state_q;
    stage_st_e         state_d;
    logic              main_v_q;
    logic              main_v_d;
    logic              skid_v_q;
    logic              skid_v_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              push_s;
    logic              pop_s;

    // Handshake qualifiers; a push in a flush cycle is dropped, a pop is not.
    always_comb begin
        push_s = in_valid & ~skid_v_q & ~flush;
        pop_s  = main_v_q & out_ready;
    end

    // Next-state and datapath steering for the three occupancy states.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (FLUSH_ZERO) begin
                main_data_d = {DATA_W{1'b0}};
                skid_data_d = {DATA_W{1'b0}};
            end else begin
                main_data_d = main_data_q;
                skid_data_d = skid_data_q;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        main_data_d = in_data;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        main_data_d = in_data;
                        state_d     = ST_ONE;
                    end else if (push_s) begin
                        // Main is stalled: park the new beat in the skid slot.
                        skid_data_d = in_data;
                        state_d     = ST_TWO;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can move things.
                    if (pop_s) begin
                        main_data_d = skid_data_q;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Valid bits are a pure decode of the next state, kept as their own flops.
    always_comb begin
        main_v_d = (state_d != ST_EMPTY);
        skid_v_d = (state_d == ST_TWO);
    end

    // State, valid and payload registers; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            if (FLUSH_ZERO) begin
                main_data_q <= {DATA_W{1'b0}};
                skid_data_q <= {DATA_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Outputs are taken directly from the registers.
    always_comb begin
        in_ready  = ~skid_v_q;
        out_valid = main_v_q;
        out_data  = main_data_q;
        occupancy = occ_count(main_v_q, skid_v_q);
    end

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_stage
// Directed and randomised self-checking bench for pipe_skid_stage.
// dut    : DATA_W=64, FLUSH_ZERO=1
// dut_nz : DATA_W=8,  FLUSH_ZERO=0
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_pipe_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  occupancy;

    logic        nz_flush;
    logic        nz_in_valid;
    logic        nz_in_ready;
    logic [7:0]  nz_in_data;
    logic        nz_out_valid;
    logic        nz_out_ready;
    logic [7:0]  nz_out_data;
    logic [1:0]  nz_occupancy;

    int errors;
    int checks;

    pipe_skid_stage #(.DATA_W(64), .FLUSH_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_stage #(.DATA_W(8), .FLUSH_ZERO(1'b0)) dut_nz (
        .clk       (clk),
        .rst       (rst),
        .flush     (nz_flush),
        .in_valid  (nz_in_valid),
        .in_ready  (nz_in_ready),
        .in_data   (nz_in_data),
        .out_valid (nz_out_valid),
        .out_ready (nz_out_ready),
        .out_data  (nz_out_data),
        .occupancy (nz_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (nz_out_valid !== 1'b0) begin errors++; $display("FAIL reset_nz_out_valid: got %b expected 0", nz_out_valid); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'(i) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d: got valid=%b data=%h ready=%b expected valid=1 data=%h ready=1",
                         i, out_valid, out_data, in_ready, 64'(i));
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_one: got occ=%0d ready=%b expected 1/1", occupancy, in_ready); end
        in_data = 64'hB;
        step();
        checks++; if (occupancy !== 2'd2 || out_data !== 64'hA) begin errors++; $display("FAIL bp_two: got occ=%0d data=%h expected 2/a", occupancy, out_data); end
        in_data = 64'hC;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", in_ready); end
        step();
        checks++; if (occupancy !== 2'd2 || out_data !== 64'hA) begin errors++; $display("FAIL bp_hold: got occ=%0d data=%h expected 2/a", occupancy, out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 64'hB || in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_pop_a: got data=%h ready=%b occ=%0d expected b/1/1", out_data, in_ready, occupancy); end
        step();
        checks++; if (out_data !== 64'hC || out_valid !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_pop_b: got data=%h valid=%b occ=%0d expected c/1/1", out_data, out_valid, occupancy); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_pop_c: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        step();
        in_data = 64'hB;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_fill: got occ=%0d expected 2", occupancy); end
        flush     = 1'b1;
        in_data   = 64'hD;
        out_ready = 1'b1;
        checks++; if (out_valid !== 1'b1 || out_data !== 64'hA) begin errors++; $display("FAIL flush_pop_beat: got valid=%b data=%h expected 1/a", out_valid, out_data); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got valid=%b occ=%0d ready=%b expected 0/0/1", out_valid, occupancy, in_ready); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL flush_zero_data: got %h expected 0", out_data); end
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_push_dropped: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush_nozero();
        nz_out_ready = 1'b0;
        nz_in_valid  = 1'b1;
        nz_in_data   = 8'h55;
        step();
        nz_in_valid = 1'b0;
        checks++; if (nz_out_valid !== 1'b1 || nz_out_data !== 8'h55) begin errors++; $display("FAIL nz_load: got valid=%b data=%h expected 1/55", nz_out_valid, nz_out_data); end
        nz_flush = 1'b1;
        step();
        nz_flush = 1'b0;
        checks++; if (nz_out_valid !== 1'b0 || nz_occupancy !== 2'd0) begin errors++; $display("FAIL nz_flush_valid: got valid=%b occ=%0d expected 0/0", nz_out_valid, nz_occupancy); end
        checks++; if (nz_out_data !== 8'h55) begin errors++; $display("FAIL nz_flush_data: got %h expected 55", nz_out_data); end
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1111;
        step();
        in_data = 64'h2222;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL rst_in_two: got valid=%b occ=%0d ready=%b data=%h expected 0/0/1/0", out_valid, occupancy, in_ready, out_data);
        end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic        exp_push;
        logic        exp_pop;
        int          rnd_fail;
        rnd_fail = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_data   = {$urandom(), $urandom()};
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
                occupancy !== 2'(q.size())) begin
                errors++;
                rnd_fail++;
                if (rnd_fail <= 5)
                    $display("FAIL rand_status c=%0d: got valid=%b ready=%b occ=%0d expected model size %0d",
                             c, out_valid, in_ready, occupancy, q.size());
            end
            exp_pop  = (q.size() != 0) && out_ready;
            exp_push = in_valid && (q.size() < 2) && !flush;
            if (exp_pop) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    rnd_fail++;
                    if (rnd_fail <= 5)
                        $display("FAIL rand_data c=%0d: got %h expected %h", c, out_data, q[0]);
                end
                void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (exp_push) begin
                q.push_back(in_data);
            end
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 64'h0;
        out_ready    = 1'b0;
        nz_flush     = 1'b0;
        nz_in_valid  = 1'b0;
        nz_in_data   = 8'h0;
        nz_out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_two();
        test_flush_nozero();
        test_reset_in_two();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_skid_stage
